filter_mac_sequencer: RTL and testbench

//  Time-multiplexed biquad (2nd-order IIR) engine: one sample at a time.

---
 rtl/filter_mac_sequencer.sv | 155 +++++++++++++++
 tb/tb_filter_mac_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_mac_sequencer.sv
// Time-multiplexed biquad engine: one shared 32xDATA_W MAC walks the 5-tap rotating coefficient ROM per sample.
// Build option FILTER_SEQ_ROUND_EN: round half up before the final shift instead of truncating toward -inf.
//
// Handshake: a sample is taken on any rising edge where in_valid & in_ready;
// in_ready is high only in IDLE with reset low, and in_valid while busy is ignored.
// out_valid is a one-cycle pulse; y_out holds its value until the next pulse.
module filter_mac_sequencer #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 16,
  parameter int ACC_W  = 51
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x_in,
  output logic                     coef_en,
  input  logic signed [31:0]       coef,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] y_out,
  output logic                     sat,
  output logic [1:0]               dbg_state
);

  localparam int PROD_W = 32 + DATA_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_SAT  = 2'd2
  } state_t;

  localparam logic signed [ACC_W-1:0] Y_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

`ifdef FILTER_SEQ_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND_OFS =
    {{(ACC_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
`else
  localparam logic signed [ACC_W-1:0] RND_OFS = '0;
`endif

  state_t                     r_state;
  logic [2:0]                 r_tap;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [DATA_W-1:0]   r_x0;
  logic signed [DATA_W-1:0]   r_x1;
  logic signed [DATA_W-1:0]   r_x2;
  logic signed [DATA_W-1:0]   r_y1;
  logic signed [DATA_W-1:0]   r_y2;
  logic                       r_out_valid;
  logic signed [DATA_W-1:0]   r_y_out;
  logic                       r_sat;

  logic signed [DATA_W-1:0]   w_op;
  logic signed [PROD_W-1:0]   w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    w_rnd;
  logic signed [ACC_W-1:0]    w_shr;
  logic                       w_sat_hi;
  logic                       w_sat_lo;
  logic signed [DATA_W-1:0]   w_y;

  // Operand order matches the ROM rotation: n1,n2,n3 on x history, d1,d2 on y history.
  always_comb begin
    w_op = r_x0;
    case (r_tap)
      3'd0:    w_op = r_x0;
      3'd1:    w_op = r_x1;
      3'd2:    w_op = r_x2;
      3'd3:    w_op = r_y1;
      3'd4:    w_op = r_y2;
      default: w_op = r_x0;
    endcase
  end

  assign w_prod     = PROD_W'(coef) * PROD_W'(w_op);
  assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

  assign w_rnd    = r_acc + RND_OFS;
  assign w_shr    = w_rnd >>> FRAC_W;
  assign w_sat_hi = (w_shr > Y_MAX);
  assign w_sat_lo = (w_shr < Y_MIN);

  always_comb begin
    w_y = w_shr[DATA_W-1:0];
    if (w_sat_hi) begin
      w_y = Y_MAX[DATA_W-1:0];
    end else if (w_sat_lo) begin
      w_y = Y_MIN[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_tap       <= 3'd0;
      r_acc       <= '0;
      r_x0        <= '0;
      r_x1        <= '0;
      r_x2        <= '0;
      r_y1        <= '0;
      r_y2        <= '0;
      r_out_valid <= 1'b0;
      r_y_out     <= '0;
      r_sat       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_sat       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x0    <= x_in;
            r_acc   <= '0;
            r_tap   <= 3'd0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod_ext;
          // Five taps, five ROM rotations: the head is back at n1 on exit.
          if (r_tap == 3'd4) begin
            r_state <= S_SAT;
          end else begin
            r_tap <= r_tap + 3'd1;
          end
        end
        S_SAT: begin
          r_y_out     <= w_y;
          r_sat       <= w_sat_hi | w_sat_lo;
          r_out_valid <= 1'b1;
          r_x2        <= r_x1;
          r_x1        <= r_x0;
          r_y2        <= r_y1;
          r_y1        <= w_y;
          r_tap       <= 3'd0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !reset;
  assign coef_en   = (r_state == S_MAC);
  assign out_valid = r_out_valid;
  assign y_out     = r_y_out;
  assign sat       = r_sat;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_filter_mac_sequencer.sv
// Bench for filter_mac_sequencer: rotating ROM model, queued expected outputs, monitor-side comparison.
module tb_filter_mac_sequencer;

  localparam int DATA_W = 16;

`ifdef FILTER_SEQ_ROUND_EN
  localparam int T2_LAST = 63;
`else
  localparam int T2_LAST = 62;
`endif

  // ---------------- clock / reset ----------------
  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     in_valid = 1'b0;
  logic signed [DATA_W-1:0] x_in = '0;
  logic                     in_ready;
  logic                     coef_en;
  logic signed [31:0]       coef;
  logic                     out_valid;
  logic signed [DATA_W-1:0] y_out;
  logic                     sat;
  logic [1:0]               dbg_state;

  always #5 clk = ~clk;

  filter_mac_sequencer #(.DATA_W(DATA_W), .FRAC_W(16), .ACC_W(51)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .coef_en   (coef_en),
    .coef      (coef),
    .out_valid (out_valid),
    .y_out     (y_out),
    .sat       (sat),
    .dbg_state (dbg_state)
  );

  // Coefficient ROM model: rotates once per coef_en cycle, head returns to n1 on reset.
  logic signed [31:0] rom [5];
  logic [2:0]         rom_ptr = 3'd0;

  always @(posedge clk) begin
    if (reset) rom_ptr <= 3'd0;
    else if (coef_en) rom_ptr <= (rom_ptr == 3'd4) ? 3'd0 : rom_ptr + 3'd1;
  end
  assign coef = rom[rom_ptr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_coef_en = 0;
  always @(posedge clk) if (!reset && coef_en) n_coef_en <= n_coef_en + 1;

  // ---------------- scoreboard state ----------------
  logic [DATA_W:0] exp_q[$];
  int              acc_q[$];
  int              checks = 0;
  int              errors = 0;
  int              n_acc = 0;
  int              n_out = 0;
  bit              chk_align = 1'b0;
  bit              chk_space = 1'b0;
  int              last_acc = -1;

  task automatic check_val(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [DATA_W:0] e;
    int              a;
    if (!reset) begin
      if (out_valid) begin
        n_out++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got y_out=%0d with no expected entry", y_out);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check_val("y_out", y_out, $signed(e[DATA_W-1:0]));
          check_val("sat", sat, e[DATA_W]);
          check_val("latency", cyc - a, 6);
        end
      end else begin
        check_val("sat_idle", sat, 0);
      end
      if (chk_align && in_ready) begin
        check_val("coef_head", coef, $signed(rom[0]));
        check_val("coef_en_idle", coef_en, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_rom(input logic signed [31:0] a, input logic signed [31:0] b,
                         input logic signed [31:0] c, input logic signed [31:0] d,
                         input logic signed [31:0] e);
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d; rom[4] = e;
  endtask

  // Presents x and returns right after the accepting edge; in_valid stays high.
  task automatic send(input logic signed [DATA_W-1:0] x, input logic signed [DATA_W-1:0] ey,
                      input logic es, input bit push);
    int waits;
    waits = 0;
    @(negedge clk);
    x_in = x;
    in_valid = 1'b1;
    while (!in_ready && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", waits);
      in_valid = 1'b0;
    end else begin
      if (push) begin
        exp_q.push_back({es, ey});
        acc_q.push_back(cyc + 1);
        n_acc++;
      end
      if (chk_space && last_acc >= 0) check_val("accept_spacing", cyc + 1 - last_acc, 7);
      last_acc = cyc + 1;
      @(posedge clk);
    end
  endtask

  task automatic drop();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int ov;
    set_rom(32'sh0001_0000, 0, 0, 0, 0);

    // Reset state
    repeat (3) @(negedge clk);
    check_val("in_ready_in_reset", in_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_y_out", y_out, 0);
    check_val("rst_sat", sat, 0);
    check_val("rst_coef_en", coef_en, 0);
    check_val("rst_state", dbg_state, 0);

    // Pass-through
    send(100, 100, 1'b0, 1'b1);     drop();
    send(-7, -7, 1'b0, 1'b1);       drop();
    send(32767, 32767, 1'b0, 1'b1); drop();
    wait_idle();

    // FIR taps with negative and fractional coefficients: y = x0 - x1 + 0.5*x2
    pulse_reset();
    set_rom(32'sh0001_0000, 32'shFFFF_0000, 32'sh0000_8000, 0, 0);
    send(100, 100, 1'b0, 1'b1); drop();
    send(40, -60, 1'b0, 1'b1);  drop();
    send(-10, 0, 1'b0, 1'b1);   drop();
    send(7, 37, 1'b0, 1'b1);    drop();
    wait_idle();

    // Recursion: impulse response of y = 0.5*x + 0.5*y1
    pulse_reset();
    set_rom(32'sh0000_8000, 0, 0, 32'sh0000_8000, 0);
    send(1000, 500, 1'b0, 1'b1);  drop();
    send(0, 250, 1'b0, 1'b1);     drop();
    send(0, 125, 1'b0, 1'b1);     drop();
    send(0, 16'(T2_LAST), 1'b0, 1'b1); drop();
    wait_idle();

    // Saturation, then confirm the clipped values went into y history
    set_rom(32'sh0002_0000, 0, 0, 0, 0);
    send(20000, 32767, 1'b1, 1'b1);   drop();
    send(-20000, -32768, 1'b1, 1'b1); drop();
    wait_idle();
    set_rom(0, 0, 0, 32'sh0000_8000, 0);
    send(0, -16384, 1'b0, 1'b1); drop();
    wait_idle();
    set_rom(0, 0, 0, 0, 32'sh0001_0000);
    send(0, -32768, 1'b0, 1'b1); drop();  // exact negative boundary: no sat
    wait_idle();

    // Back-to-back with in_valid held high
    set_rom(32'sh0001_0000, 0, 0, 0, 0);
    begin : b2b
      int n0;
      n0 = n_coef_en;
      chk_align = 1'b1;
      chk_space = 1'b1;
      last_acc = -1;
      for (int i = 0; i < 50; i++) begin
        send(16'(i * 613 - 15000), 16'(i * 613 - 15000), 1'b0, 1'b1);
      end
      drop();
      wait_idle();
      chk_align = 1'b0;
      chk_space = 1'b0;
      check_val("coef_en_count", n_coef_en - n0, 250);
    end

    // Reset during MAC tap 2 clears history and discards the sample
    set_rom(32'sh0001_0000, 0, 0, 32'sh0001_0000, 0);
    send(300, 15337, 1'b0, 1'b1); drop();
    wait_idle();
    send(700, 0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_val("mid_mac_state", dbg_state, 1);
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check_val("in_ready_in_reset2", in_ready, 0);
    reset = 1'b0;
    ov = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) ov++;
    end
    check_val("aborted_out_valid", ov, 0);
    check_val("aborted_y_out", y_out, 0);
    check_val("post_reset_ready", in_ready, 1);
    send(100, 100, 1'b0, 1'b1); drop();
    wait_idle();

    // in_valid toggled while busy: ignored, in_ready low throughout
    send(5, 105, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_val("in_ready_busy", in_ready, 0);
      x_in = 16'(k * 1111);
      in_valid = (k < 5) ? (k % 2 == 0) : 1'b0;
    end
    send(-20, 85, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_val("in_ready_busy", in_ready, 0);
      x_in = 16'(-k * 977);
      in_valid = (k < 5) ? (k % 2 == 1) : 1'b0;
    end
    send(1000, 1085, 1'b0, 1'b1); drop();
    wait_idle();

    check_val("exp_q_empty", exp_q.size(), 0);
    check_val("out_eq_accept", n_out, n_acc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
